// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage of the multi-cycle MIPS core.
//
// Holds the PC and fetches one instruction word at a time from instruction
// memory over a req/ack handshake. The fetched word is held for the
// decode/control stage. The next PC is then chosen from the decoded control
// flags, the ALU Zero flag and the branch target. instr_valid marks the single
// commit cycle of each instruction, so downstream writes happen exactly once.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   imem_req     out  fetch request (high only in FETCH)
//   imem_addr    out  word address = pc[IMEM_ADDR_W+1:2]
//   imem_ack     in   imem_rdata valid this cycle (honoured only in FETCH)
//   imem_rdata   in   instruction word from memory
//   stall        in   holds the commit in EXEC
//   Jr, Jmp, Jal, Branch, nBranch  in  decoded control flags
//   Zero         in   ALU zero flag
//   Addr_result  in   branch target
//   Read_data_1  in   rs value (jr target)
//   Instruction  out  held instruction word
//   instr_valid  out  commit strobe
//   pc           out  address of the held instruction
//   link_addr    out  pc + 4 (jal link value)
//   fetch_fault  out  sticky misaligned-target fault
module ifetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_ADDR_W = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   imem_req,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic                   imem_ack,
   input  logic [31:0]            imem_rdata,
   input  logic                   stall,
   input  logic                   Jr,
   input  logic                   Jmp,
   input  logic                   Jal,
   input  logic                   Branch,
   input  logic                   nBranch,
   input  logic                   Zero,
   input  logic [31:0]            Addr_result,
   input  logic [31:0]            Read_data_1,
   output logic [31:0]            Instruction,
   output logic                   instr_valid,
   output logic [31:0]            pc,
   output logic [31:0]            link_addr,
   output logic                   fetch_fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic [31:0] instr_next;
   logic        fault_next;
   logic [31:0] pc_plus4;
   logic [31:0] jump_target;
   logic        take_branch;
   logic [31:0] next_pc;

   // Wraps modulo 2^32, so 0xFFFFFFFC + 4 gives 0.
   assign pc_plus4    = pc + 32'd4;
   assign link_addr   = pc_plus4;
   assign jump_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
   assign take_branch = (Branch && Zero) || (nBranch && !Zero);
   // pc only changes on a commit, so the address is stable while imem_req is high.
   assign imem_addr   = pc[IMEM_ADDR_W+1:2];

   // Target selection for the held instruction, with jr having the highest priority.
   always_comb begin
      next_pc = pc_plus4;
      if (Jr) begin
         next_pc = Read_data_1;
      end else if (Jmp || Jal) begin
         next_pc = jump_target;
      end else if (take_branch) begin
         next_pc = Addr_result;
      end else begin
         next_pc = pc_plus4;
      end
   end

   // Sequencer next-state, datapath next values and handshake/commit outputs.
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      instr_next  = Instruction;
      fault_next  = fetch_fault;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_next = imem_rdata;
               state_next = EXEC;
            end else begin
               state_next = FETCH;
            end
         end
         EXEC: begin
            if (stall) begin
               state_next = EXEC;
            end else begin
               instr_valid = 1'b1;
               // A misaligned target is not loaded; the unit parks in HALT instead.
               if (next_pc[1:0] != 2'b00) begin
                  fault_next = 1'b1;
                  state_next = HALT;
               end else begin
                  pc_next    = next_pc;
                  state_next = FETCH;
               end
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, PC, held instruction and sticky fault registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         Instruction <= 32'h0000_0000;
         fetch_fault <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         Instruction <= instr_next;
         fetch_fault <= fault_next;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
// Inputs are driven 1 ns after the rising edge and outputs are sampled a
// further 1 ns later, well away from the next active edge.
module tb_ifetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0000_0000;
   logic        stall = 1'b0;
   logic        Jr = 1'b0, Jmp = 1'b0, Jal = 1'b0, Branch = 1'b0, nBranch = 1'b0, Zero = 1'b0;
   logic [31:0] Addr_result = 32'h0000_0000;
   logic [31:0] Read_data_1 = 32'h0000_0000;
   logic [31:0] Instruction;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(14)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .Jr          (Jr),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Zero        (Zero),
      .Addr_result (Addr_result),
      .Read_data_1 (Read_data_1),
      .Instruction (Instruction),
      .instr_valid (instr_valid),
      .pc          (pc),
      .link_addr   (link_addr),
      .fetch_fault (fetch_fault)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in FETCH: checks the request, returns w with zero wait states and
   // checks the word is held in EXEC.
   task automatic fetch_word(input string tag, input logic [31:0] w, input logic [31:0] exp_pc);
      #1;
      chk({tag, " req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, " addr"}, {18'd0, imem_addr}, {18'd0, exp_pc[15:2]});
      chk({tag, " valid_fetch"}, {31'd0, instr_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = w;
      cyc();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0000_0000;
      #1;
      chk({tag, " instr"}, Instruction, w);
      chk({tag, " pc"}, pc, exp_pc);
      chk({tag, " req_exec"}, {31'd0, imem_req}, 32'd0);
   endtask

   // Called in EXEC: applies control flags for one commit and checks the new pc.
   task automatic commit(input string tag, input logic jr, input logic jmp, input logic jal,
                         input logic br, input logic nbr, input logic zr,
                         input logic [31:0] ares, input logic [31:0] rd1,
                         input logic [31:0] exp_next);
      Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = zr;
      Addr_result = ares;
      Read_data_1 = rd1;
      #1;
      chk({tag, " valid_commit"}, {31'd0, instr_valid}, 32'd1);
      cyc();
      Jr = 1'b0; Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; nBranch = 1'b0; Zero = 1'b0;
      Addr_result = 32'h0000_0000;
      Read_data_1 = 32'h0000_0000;
      #1;
      chk({tag, " next_pc"}, pc, exp_next);
      chk({tag, " refetch_req"}, {31'd0, imem_req}, 32'd1);
      chk({tag, " valid_after"}, {31'd0, instr_valid}, 32'd0);
   endtask

   initial begin
      // Reset state.
      repeat (2) cyc();
      chk("rst pc", pc, 32'h0000_0000);
      chk("rst instr", Instruction, 32'h0000_0000);
      chk("rst req", {31'd0, imem_req}, 32'd0);
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst fault", {31'd0, fetch_fault}, 32'd0);
      reset = 1'b1;
      #1;
      chk("idle req", {31'd0, imem_req}, 32'd0);
      cyc();

      // Zero-wait fetches of two addi instructions.
      fetch_word("addi0", 32'h2008_0001, 32'h0000_0000);
      chk("addi0 link", link_addr, 32'h0000_0004);
      commit("addi0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);
      fetch_word("addi1", 32'h2009_0002, 32'h0000_0004);
      commit("addi1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0008);

      // Three wait states: request and address held, nothing captured early.
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wait req", {31'd0, imem_req}, 32'd1);
         chk("wait addr", {18'd0, imem_addr}, 32'h0000_0002);
         cyc();
         chk("wait instr", Instruction, 32'h2009_0002);
      end
      // jal 0x0000100 arrives on the fourth request cycle.
      fetch_word("jal", 32'h0C00_0100, 32'h0000_0008);
      chk("jal link", link_addr, 32'h0000_000C);
      // Stray ack in EXEC (held by stall) must not overwrite the instruction.
      stall      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1111_1111;
      cyc();
      imem_ack   = 1'b0;
      stall      = 1'b0;
      #1;
      chk("stray instr", Instruction, 32'h0C00_0100);
      chk("stray pc", pc, 32'h0000_0008);
      commit("jal", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0400);

      // jr with Jmp also set: Jr wins (Jmp target would be 0x0F800020).
      fetch_word("jr", 32'h03E0_0008, 32'h0000_0400);
      commit("jr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_000C, 32'h0000_000C);

      // Five stall cycles in EXEC, then the commit.
      fetch_word("stall", 32'h0000_0020, 32'h0000_000C);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall valid", {31'd0, instr_valid}, 32'd0);
         chk("stall pc", pc, 32'h0000_000C);
         cyc();
      end
      stall = 1'b0;
      commit("stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0010);

      // beq taken, return via jr, beq not taken, bne taken.
      fetch_word("beq_t", 32'h1109_000B, 32'h0000_0010);
      commit("beq_t", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0000_0040);
      fetch_word("back", 32'h03E0_0008, 32'h0000_0040);
      commit("back", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 32'h0000_0010);
      fetch_word("beq_n", 32'h1109_000B, 32'h0000_0010);
      commit("beq_n", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0014);
      fetch_word("bne_t", 32'h1509_000A, 32'h0000_0014);
      commit("bne_t", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040);

      // PC wrap: jump to the last word, imem_addr aliases, pc+4 wraps to 0.
      fetch_word("to_top", 32'h03E0_0008, 32'h0000_0040);
      commit("to_top", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      fetch_word("wrap", 32'h0000_0000, 32'hFFFF_FFFC);
      chk("wrap link", link_addr, 32'h0000_0000);
      commit("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0000);
      fetch_word("nop", 32'h0000_0000, 32'h0000_0000);
      commit("nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);

      // Misaligned jr target: fault, pc kept, HALT.
      fetch_word("mis", 32'h03E0_0008, 32'h0000_0004);
      Jr = 1'b1;
      Read_data_1 = 32'h0000_0022;
      #1;
      chk("mis valid", {31'd0, instr_valid}, 32'd1);
      cyc();
      Jr = 1'b0;
      Read_data_1 = 32'h0000_0000;
      #1;
      chk("mis fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis pc", pc, 32'h0000_0004);
      chk("mis req", {31'd0, imem_req}, 32'd0);
      // HALT ignores ack and stays put.
      imem_ack = 1'b1;
      repeat (2) cyc();
      imem_ack = 1'b0;
      chk("halt req", {31'd0, imem_req}, 32'd0);
      chk("halt valid", {31'd0, instr_valid}, 32'd0);
      chk("halt pc", pc, 32'h0000_0004);
      chk("halt fault", {31'd0, fetch_fault}, 32'd1);

      // Reset clears the fault and restarts from RESET_PC.
      reset = 1'b0;
      #1;
      chk("hrst fault", {31'd0, fetch_fault}, 32'd0);
      chk("hrst pc", pc, 32'h0000_0000);
      cyc();
      reset = 1'b1;
      cyc();
      fetch_word("re0", 32'h2008_0001, 32'h0000_0000);
      commit("re0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0004);

      // Reset asserted mid-cycle in FETCH with an ack pending.
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      #2;
      reset = 1'b0;
      #1;
      chk("arst req", {31'd0, imem_req}, 32'd0);
      chk("arst pc", pc, 32'h0000_0000);
      chk("arst instr", Instruction, 32'h0000_0000);
      cyc();
      chk("arst hold instr", Instruction, 32'h0000_0000);
      chk("arst hold req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b0;
      reset    = 1'b1;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle MIPS core. Holds the PC and fetches from instruction memory over a req/ack handshake.
- Presents the held instruction to the decode/control stage and computes the next PC from the decoded control flags, ALU Zero and branch target.
- Gates each instruction's commit with instr_valid so downstream register and memory writes happen exactly once per instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- IMEM_ADDR_W, 14, word-address width of instruction memory.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  IMEM_ADDR_W  word address, equal to pc[IMEM_ADDR_W+1:2].
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  holds commit (IO wait / debugger).
- Jr, Jmp, Jal, Branch, nBranch  in  1 each  decoded control flags for the held instruction.
- Zero  in  1  ALU zero flag.
- Addr_result  in  32  branch target from ALU.
- Read_data_1  in  32  rs value, used by jr.
- Instruction  out  32  held instruction word.
- instr_valid  out  1  commit strobe.
- pc  out  32  address of the held instruction.
- link_addr  out  32  pc+4, combinational; jal writes it to $31.
- fetch_fault  out  1  sticky misaligned-target fault.

Behaviour:
- Reset values: pc=RESET_PC, Instruction=0, imem_req=0, instr_valid=0, fetch_fault=0, state=IDLE. Reset applies immediately and asynchronously, including mid-fetch; any pending ack is discarded.
- States are IDLE, FETCH, EXEC and HALT.
- IDLE: always moves to FETCH on the next clock. imem_req=0.
- FETCH: imem_req=1. imem_addr is stable for as long as imem_req is high. On a cycle with imem_ack=1, capture Instruction<=imem_rdata and go to EXEC. Otherwise stay in FETCH; wait states are unbounded.
- imem_ack outside FETCH is ignored.
- stall has no effect in FETCH.
- EXEC: Instruction and pc are held. instr_valid = (state==EXEC) && !stall, purely combinational.
  - stall=1: stay in EXEC, pc unchanged, instr_valid=0.
  - stall=0 (commit cycle): pc<=next_pc and state<=FETCH. No commit happens without a preceding ack.
- next_pc, priority highest first:
  1. Jr: Read_data_1.
  2. Jmp or Jal: {pc_plus4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch && Zero) || (nBranch && !Zero): Addr_result.
  4. Otherwise: pc_plus4.
- Arithmetic: pc_plus4 = pc + 32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0). imem_addr silently aliases when pc exceeds the memory size.
- Misalignment: if the commit-cycle next_pc[1:0] != 0, pc is not updated, fetch_fault<=1 and state<=HALT.
- HALT: imem_req=0 and instr_valid=0. Only reset exits HALT.
- Throughput: with zero-wait memory (ack in the first FETCH cycle), 2 cycles per instruction; each memory wait state adds 1 cycle.

Test Plan:
- Reset, then zero-wait memory returning 0x20080001, 0x20090002 (addi) -> imem_req rises 1 cycle after reset release. pc sequence 0x0, 0x4, 0x8. instr_valid pulses one cycle every 2 cycles. Instruction values match.
- Memory with 3 wait states -> imem_addr stable and imem_req high for 4 cycles. Instruction captured only on the ack cycle. A stray ack in EXEC is ignored.
- beq at pc 0x10, Addr_result=0x40: Zero=1 -> pc=0x40. Repeat with Zero=0 -> pc=0x14. bne with Zero=0 -> 0x40.
- jal 0x0000100 at pc 0x8 -> link_addr=0xC during EXEC, next pc=0x400. Then jr with Read_data_1=0xC -> pc=0xC. With Jr and Jmp both set, Jr wins.
- stall=1 for 5 cycles in EXEC -> instr_valid=0 and pc constant. instr_valid=1 on the cycle stall falls, then FETCH.
- jr with Read_data_1=0x00000022 -> fetch_fault=1, pc unchanged, HALT with imem_req=0. Asserting reset mid-FETCH clears the fault, forces pc=RESET_PC, and drops imem_req the same cycle.
